// File: rtl/vrf_pkg.sv
// Shared constants, lane-count helper and clear-sequencer state type for the
// banked vector register file.
package vrf_pkg;

    localparam int VRF_NUM_REGS = 4;
    localparam int VRF_VLEN     = 512;
    localparam int VRF_ELEM_W   = 32;

    function automatic int vrf_lanes(input int vlen, input int elem_w);
        return vlen / elem_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_e;

endpackage

// File: rtl/vrf_lane_merge.sv
// Per-element select between old contents and two masked write sources;
// port 2 takes priority where both sources cover the same element.
module vrf_lane_merge
    import vrf_pkg::*;
#(
    parameter  int VLEN   = VRF_VLEN,
    parameter  int ELEM_W = VRF_ELEM_W,
    localparam int LANES  = vrf_lanes(VLEN, ELEM_W)
) (
    input  logic [VLEN-1:0]  old_data,
    input  logic [VLEN-1:0]  data_1,
    input  logic [LANES-1:0] mask_1,
    input  logic             hit_1,
    input  logic [VLEN-1:0]  data_2,
    input  logic [LANES-1:0] mask_2,
    input  logic             hit_2,
    output logic [VLEN-1:0]  merged
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign merged[gi*ELEM_W +: ELEM_W] =
            (hit_2 && mask_2[gi]) ? data_2[gi*ELEM_W +: ELEM_W] :
            (hit_1 && mask_1[gi]) ? data_1[gi*ELEM_W +: ELEM_W] :
                                    old_data[gi*ELEM_W +: ELEM_W];
    end

endmodule

// File: rtl/vrf_banked.sv
// Parametrised vector register file: two lane-masked write ports, two
// write-first registered read ports and a one-register-per-cycle clear engine.
module vrf_banked
    import vrf_pkg::*;
#(
    parameter  int NUM_REGS = VRF_NUM_REGS,
    parameter  int VLEN     = VRF_VLEN,
    parameter  int ELEM_W   = VRF_ELEM_W,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int LANES    = vrf_lanes(VLEN, ELEM_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_1,
    input  logic [ADDR_W-1:0]        wr_addr_1,
    input  logic [VLEN-1:0]          wr_data_1,
    input  logic [LANES-1:0]         wr_mask_1,
    input  logic                     wr_en_2,
    input  logic [ADDR_W-1:0]        wr_addr_2,
    input  logic [VLEN-1:0]          wr_data_2,
    input  logic [LANES-1:0]         wr_mask_2,
    output logic                     wr_ready,
    input  logic                     rd_en_a,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    output logic signed [VLEN-1:0]   rd_data_a,
    output logic                     rd_valid_a,
    input  logic                     rd_en_b,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic signed [VLEN-1:0]   rd_data_b,
    output logic                     rd_valid_b,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic [NUM_REGS*VLEN-1:0] regs_flat
);

    clr_state_e          state_reg, state_next;
    logic [ADDR_W-1:0]   clr_idx_reg, clr_idx_next;
    logic [VLEN-1:0]     regs_reg [NUM_REGS];
    logic                clearing;
    logic                wr_fire_1, wr_fire_2;

    assign clearing  = (state_reg == CLEAR);
    assign clr_busy  = (state_reg != IDLE);
    assign clr_done  = (state_reg == DONE);
    assign wr_ready  = !clr_busy;
    assign wr_fire_1 = wr_en_1 && wr_ready;
    assign wr_fire_2 = wr_en_2 && wr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_idx_next = '0;
                end
            end
            CLEAR: begin
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == ADDR_W'(NUM_REGS - 1))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Storage: writes and the clear never coincide because wr_ready is low while clearing.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic            hit_1, hit_2;
        logic [VLEN-1:0] reg_next;

        assign hit_1 = wr_fire_1 && (wr_addr_1 == ADDR_W'(gi));
        assign hit_2 = wr_fire_2 && (wr_addr_2 == ADDR_W'(gi));

        vrf_lane_merge #(.VLEN(VLEN), .ELEM_W(ELEM_W)) u_merge (
            .old_data (regs_reg[gi]),
            .data_1   (wr_data_1),
            .mask_1   (wr_mask_1),
            .hit_1    (hit_1),
            .data_2   (wr_data_2),
            .mask_2   (wr_mask_2),
            .hit_2    (hit_2),
            .merged   (reg_next)
        );

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                regs_reg[gi] <= '0;
            else if (clearing && (clr_idx_reg == ADDR_W'(gi)))
                regs_reg[gi] <= '0;
            else if (hit_1 || hit_2)
                regs_reg[gi] <= reg_next;
        end

        assign regs_flat[gi*VLEN +: VLEN] = regs_reg[gi];
    end

    logic              rd_en_v    [2];
    logic [ADDR_W-1:0] rd_addr_v  [2];
    logic [VLEN-1:0]   rd_data_v  [2];
    logic              rd_valid_v [2];

    assign rd_en_v[0]   = rd_en_a;
    assign rd_en_v[1]   = rd_en_b;
    assign rd_addr_v[0] = rd_addr_a;
    assign rd_addr_v[1] = rd_addr_b;
    assign rd_data_a    = rd_data_v[0];
    assign rd_data_b    = rd_data_v[1];
    assign rd_valid_a   = rd_valid_v[0];
    assign rd_valid_b   = rd_valid_v[1];

    // Read ports see the post-edge contents: same-edge writes bypassed, cleared register reads 0.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic            in_range, hit_1, hit_2, clr_hit;
        logic [VLEN-1:0] rd_old, rd_merged;

        assign in_range = int'(rd_addr_v[gi]) < NUM_REGS;
        assign rd_old   = in_range ? regs_reg[rd_addr_v[gi]] : '0;
        assign hit_1    = in_range && wr_fire_1 && (wr_addr_1 == rd_addr_v[gi]);
        assign hit_2    = in_range && wr_fire_2 && (wr_addr_2 == rd_addr_v[gi]);
        assign clr_hit  = clearing && (clr_idx_reg == rd_addr_v[gi]);

        vrf_lane_merge #(.VLEN(VLEN), .ELEM_W(ELEM_W)) u_bypass (
            .old_data (rd_old),
            .data_1   (wr_data_1),
            .mask_1   (wr_mask_1),
            .hit_1    (hit_1),
            .data_2   (wr_data_2),
            .mask_2   (wr_mask_2),
            .hit_2    (hit_2),
            .merged   (rd_merged)
        );

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_data_v[gi]  <= '0;
                rd_valid_v[gi] <= 1'b0;
            end else begin
                rd_valid_v[gi] <= rd_en_v[gi];
                if (rd_en_v[gi])
                    rd_data_v[gi] <= clr_hit ? '0 : rd_merged;
            end
        end
    end

endmodule

// File: tb/tb_vrf_banked.sv
// Scoreboard bench for vrf_banked: stimulus pushes expected read data into
// per-port queues, a negedge monitor pops and compares on every rd_valid.
module tb_vrf_banked;

    localparam int NR = 4;
    localparam int VL = 512;
    localparam int LN = 16;
    localparam int AW = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               wr_en_1 = 1'b0, wr_en_2 = 1'b0;
    logic [AW-1:0]      wr_addr_1 = '0, wr_addr_2 = '0;
    logic [VL-1:0]      wr_data_1 = '0, wr_data_2 = '0;
    logic [LN-1:0]      wr_mask_1 = '0, wr_mask_2 = '0;
    logic               wr_ready;
    logic               rd_en_a = 1'b0, rd_en_b = 1'b0;
    logic [AW-1:0]      rd_addr_a = '0, rd_addr_b = '0;
    logic signed [VL-1:0] rd_data_a, rd_data_b;
    logic               rd_valid_a, rd_valid_b;
    logic               clr_req = 1'b0;
    logic               clr_busy, clr_done;
    logic [NR*VL-1:0]   regs_flat;

    int n_checks = 0;
    int n_pass   = 0;
    logic [VL-1:0] exp_a [$];
    logic [VL-1:0] exp_b [$];

    vrf_banked dut (
        .clk(clk), .reset(reset),
        .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1), .wr_mask_1(wr_mask_1),
        .wr_en_2(wr_en_2), .wr_addr_2(wr_addr_2), .wr_data_2(wr_data_2), .wr_mask_2(wr_mask_2),
        .wr_ready(wr_ready),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s", name);
        end else begin
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s = %0d", name, act);
        end else begin
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid read is matched against the oldest expectation for that port.
    always @(negedge clk) begin
        if (reset && rd_valid_a) begin
            if (exp_a.size() == 0) check_int("rd_a_unexpected", 1, 0);
            else check_vec("rd_a_data", rd_data_a, exp_a.pop_front());
        end
        if (reset && rd_valid_b) begin
            if (exp_b.size() == 0) check_int("rd_b_unexpected", 1, 0);
            else check_vec("rd_b_data", rd_data_b, exp_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    logic [VL-1:0] pat_e1, pat_e2, pat_r3, pat_ones;
    int busy_cnt, done_at, done_cnt, ready_bad;

    initial begin
        pat_e1   = {{8{32'h11111111}}, {8{32'h22222222}}};
        pat_e2   = {{12{32'hA5A5A5A5}}, {4{32'h0B0B0B0B}}};
        pat_r3   = {16{32'h33333333}};
        pat_ones = '1;

        // Reset state
        repeat (3) tick();
        check_int("rst_wr_ready", longint'(wr_ready), 1);
        check_int("rst_rd_valid_a", longint'(rd_valid_a), 0);
        check_int("rst_clr_busy", longint'(clr_busy), 0);
        for (int r = 0; r < NR; r++) check_vec($sformatf("rst_reg%0d", r), regs_flat[r*VL +: VL], '0);
        reset = 1'b1;
        tick();

        // Read reg3 after reset: zero data, valid one cycle later
        rd_en_a = 1'b1; rd_addr_a = 2'd3; exp_a.push_back('0);
        tick();
        rd_en_a = 1'b0;
        tick();

        // Full write then partial overwrite of reg1
        wr_en_1 = 1'b1; wr_addr_1 = 2'd1; wr_data_1 = {16{32'h11111111}}; wr_mask_1 = 16'hFFFF;
        tick();
        wr_en_1 = 1'b0;
        wr_en_2 = 1'b1; wr_addr_2 = 2'd1; wr_data_2 = {16{32'h22222222}}; wr_mask_2 = 16'h00FF;
        tick();
        wr_en_2 = 1'b0;
        check_vec("reg1_partial", regs_flat[1*VL +: VL], pat_e1);
        rd_en_b = 1'b1; rd_addr_b = 2'd1; exp_b.push_back(pat_e1);
        tick();
        rd_en_b = 1'b0;

        // Same-edge dual write with port-2 priority, bypassed onto read A
        wr_en_1 = 1'b1; wr_addr_1 = 2'd2; wr_data_1 = {16{32'hA5A5A5A5}}; wr_mask_1 = 16'hFFFF;
        wr_en_2 = 1'b1; wr_addr_2 = 2'd2; wr_data_2 = {16{32'h0B0B0B0B}}; wr_mask_2 = 16'h000F;
        rd_en_a = 1'b1; rd_addr_a = 2'd2; exp_a.push_back(pat_e2);
        tick();
        wr_en_1 = 1'b0; wr_en_2 = 1'b0; rd_en_a = 1'b0;
        check_vec("reg2_merge", regs_flat[2*VL +: VL], pat_e2);

        // Zero mask is a no-op
        wr_en_1 = 1'b1; wr_addr_1 = 2'd1; wr_data_1 = '0; wr_mask_1 = 16'h0000;
        tick();
        wr_en_1 = 1'b0;
        check_vec("mask0_noop", regs_flat[1*VL +: VL], pat_e1);

        // Signed read of all-ones reg0
        wr_en_1 = 1'b1; wr_addr_1 = 2'd0; wr_data_1 = pat_ones; wr_mask_1 = 16'hFFFF;
        tick();
        wr_en_1 = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 2'd0; exp_a.push_back(pat_ones);
        tick();
        rd_en_a = 1'b0;
        check_int("signed_read", longint'($signed(rd_data_a)), -1);

        // Fill reg3, then bulk clear
        wr_en_1 = 1'b1; wr_addr_1 = 2'd3; wr_data_1 = pat_r3; wr_mask_1 = 16'hFFFF;
        tick();
        wr_en_1 = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0; done_at = 0; done_cnt = 0; ready_bad = 0;
        for (int i = 0; i < 10; i++) begin
            wr_en_1 = 1'b0; rd_en_a = 1'b0;
            if (clr_busy) busy_cnt++;
            if (clr_done) begin done_at = busy_cnt; done_cnt++; end
            if (clr_busy && wr_ready) ready_bad++;
            if (clr_busy && busy_cnt == 2) begin
                // Dropped write to reg0 and a read of the register cleared on this edge
                wr_en_1 = 1'b1; wr_addr_1 = 2'd0; wr_data_1 = pat_ones; wr_mask_1 = 16'hFFFF;
                rd_en_a = 1'b1; rd_addr_a = 2'd1; exp_a.push_back('0);
            end
            tick();
        end
        wr_en_1 = 1'b0; rd_en_a = 1'b0;
        check_int("clr_busy_cycles", busy_cnt, 5);
        check_int("clr_done_cycle", done_at, 5);
        check_int("clr_done_pulses", done_cnt, 1);
        check_int("clr_wr_ready_low", ready_bad, 0);
        for (int r = 0; r < NR; r++) check_vec($sformatf("clr_reg%0d", r), regs_flat[r*VL +: VL], '0);

        // Reset in the middle of a clear
        wr_en_1 = 1'b1; wr_addr_1 = 2'd3; wr_data_1 = pat_r3; wr_mask_1 = 16'hFFFF;
        tick();
        wr_en_1 = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 2'd3; exp_a.push_back(pat_r3);
        tick();
        rd_en_a = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        check_int("amid_clr_busy", longint'(clr_busy), 0);
        check_int("amid_clr_done", longint'(clr_done), 0);
        check_int("amid_wr_ready", longint'(wr_ready), 1);
        check_int("amid_rd_valid_a", longint'(rd_valid_a), 0);
        check_vec("amid_rd_data_a", rd_data_a, '0);
        check_vec("amid_reg3", regs_flat[3*VL +: VL], '0);
        tick();
        tick();
        reset = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (clr_done) done_cnt++;
            if (clr_busy) busy_cnt++;
        end
        check_int("post_rst_no_done", done_cnt, 0);
        check_int("post_rst_idle", busy_cnt, 0);

        check_int("queue_a_drained", exp_a.size(), 0);
        check_int("queue_b_drained", exp_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vrf_banked.md
Name: vrf_banked

Overview:
- Parametrised successor to the fixed 4x512 vector register file.
- NUM_REGS registers of VLEN bits, each split into LANES = VLEN/ELEM_W elements.
- Two lane-masked write ports and two registered read ports with write-first bypass.
- A sequenced bulk-clear engine zeroes the file one register per cycle.
- Sits between the vector execution units (writers) and the operand fetch stage (readers).

Parameters:
- NUM_REGS, 4: number of vector registers; must be at least 2.
- VLEN, 512: bits per register.
- ELEM_W, 32: element width; VLEN must be a multiple of ELEM_W.
- ADDR_W, $clog2(NUM_REGS): register address width; derived, not overridden.

Ports:
- clk  in  1  Single clock. All state changes on the posedge.
- reset  in  1  Asynchronous, active-low reset.
- wr_en_1  in  1  Write port 1 enable.
- wr_addr_1  in  ADDR_W  Write port 1 register index.
- wr_data_1  in  VLEN  Write port 1 data.
- wr_mask_1  in  LANES  Write port 1 per-element enable. Bit i covers bits [i*ELEM_W +: ELEM_W].
- wr_en_2, wr_addr_2, wr_data_2, wr_mask_2  in  as above  Write port 2.
- wr_ready  out  1  High when writes are accepted; low during a clear.
- rd_en_a  in  1  Read port A request.
- rd_addr_a  in  ADDR_W  Read port A index.
- rd_data_a  out  VLEN  Read port A data, signed contents.
- rd_valid_a  out  1  Read port A data valid.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b  as A  Read port B.
- clr_req  in  1  Request a bulk clear.
- clr_busy  out  1  Clear in progress.
- clr_done  out  1  One-cycle pulse when a clear completes.
- regs_flat  out  NUM_REGS*VLEN  All registers concatenated, reg 0 at the LSBs. Debug and observation only.

Behaviour:
- Reset (asserted low, asynchronous):
  - All registers are 0.
  - rd_data_a and rd_data_b are 0.
  - rd_valid_a, rd_valid_b, clr_busy and clr_done are 0.
  - wr_ready is 1.
  - The FSM goes to IDLE and the clear index to 0.
  - Reset asserted mid-clear aborts the clear; no clr_done is issued.
- Writes:
  - A write is accepted on the posedge when wr_en_x && wr_ready.
  - Only the elements whose mask bit is 1 are updated.
  - A mask of 0 is a legal no-op.
  - A write offered while wr_ready=0 is dropped. The producer must hold it until wr_ready=1.
- Simultaneous writes to the same register:
  - Merge per element.
  - Where both masks are set for an element, port 2 wins.
- Reads:
  - Latency is 1 cycle: rd_data_x and rd_valid_x are registered at the posedge where rd_en_x is sampled.
  - rd_valid_x = rd_en_x delayed by one cycle.
  - rd_data_x holds its last value when rd_en_x=0.
  - Reads are write-first. A write accepted on the same edge to the same address is bypassed per element, with port-2 priority, so rd_data shows the post-write contents.
  - Reads are always allowed, including during a clear.
  - A read of the register being cleared on that edge returns 0.
- Clear FSM:
  - States: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req=1. Index is set to 0 and clr_busy rises on the next cycle.
  - In CLEAR, each cycle zeroes reg[index] and increments the index.
  - At index NUM_REGS-1 the FSM goes to DONE.
  - DONE lasts one cycle: clr_done=1, then IDLE.
  - clr_busy is 1 in CLEAR and DONE.
  - wr_ready = !clr_busy. The clear occupies NUM_REGS+1 cycles.
  - clr_req is ignored outside IDLE; there is no queuing.
  - A write accepted on the same edge clr_req is sampled completes normally before the clear begins.
- regs_flat is combinational from storage and reflects the contents after the last edge.
- Addresses are always in range for power-of-two NUM_REGS. For other values, writes to addresses >= NUM_REGS are ignored and reads return 0.

Decomposition:
- Package vrf_pkg:
  - Default constants: VRF_NUM_REGS, VRF_VLEN, VRF_ELEM_W.
  - LANES derivation function.
  - Clear FSM state enum clr_state_e {IDLE, CLEAR, DONE}.
- Sub-module vrf_lane_merge: combinational per-element select. Inputs are old data, two data/mask pairs and two hit flags; output is the merged vector.
  - Used once per register for storage update.
  - Used once per read port for bypass.

Test Plan:
- Reset low, then high: regs_flat == 0, wr_ready=1, rd_valid_a=0; read reg 3 -> rd_data_a=0 one cycle later with rd_valid_a=1.
- wr_1 reg1 data=all 0x11111111, mask=0xFFFF; then wr_2 reg1 data=all 0x22222222, mask=0x00FF -> reg1 lanes 0-7 = 0x22222222, lanes 8-15 = 0x11111111.
- Same edge: wr_1 reg2 mask=0xFFFF data=A, wr_2 reg2 mask=0x000F data=B, rd_a reg2 -> next cycle rd_data_a lanes 0-3=B, 4-15=A, equal to stored reg2.
- Load all registers nonzero, pulse clr_req -> clr_busy for 5 cycles, clr_done on the 5th, wr_ready=0 throughout; a wr_1 offered mid-clear is dropped; afterwards regs_flat == 0.
- Assert reset low mid-clear at index 2 -> outputs at reset values immediately (asynchronous), no clr_done, FSM IDLE after release.
- Signed read: write reg0 with all-ones -> rd_data_a interpreted signed == -1.
